// File: rtl/seg7_pkg.sv
// Shared constants for the scrolling 7-segment driver: glyph encodings and FSM states.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_H = 7'h09;
    localparam logic [6:0] SEG_L = 7'h47;
    localparam logic [6:0] SEG_O = 7'h40;
    localparam logic [6:0] SEG_P = 7'h0C;
    localparam logic [6:0] SEG_U = 7'h41;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated modulo-DIV counter; strobe is high for the one enabled cycle in which
// the count wraps, so a stalled enable freezes the phase exactly.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic strobe
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign strobe = en && (cnt_reg == LAST);

endmodule

// File: rtl/seg7_scroll_display.sv
// Scrolling-message driver for a multiplexed active-low 7-segment display.
// Message RAM feeds a shift window that is scanned onto the anodes one digit at a time.
module seg7_scroll_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 32,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 25000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [6:0]                     wr_data,
    input  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    input  logic                           run,
    input  logic                           dir,
    input  logic                           loop,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [6:0]                     seg,
    output logic                           busy,
    output logic                           done
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = $clog2(NUM_DIGITS + 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [6:0]            mem [MSG_DEPTH];
    logic [6:0]            rd_glyph;

    state_t                state_reg, state_next;
    logic [AW-1:0]         ptr_reg, ptr_next;
    logic [LW-1:0]         len_reg, len_next;
    logic [DW-1:0]         dcnt_reg, dcnt_next;
    logic                  done_reg, done_next;
    logic [LW-1:0]         len_clamped;
    logic [LW-1:0]         last_ptr;

    logic                  shift_en;
    logic [6:0]            shift_glyph;
    logic [6:0]            window_reg [NUM_DIGITS];
    logic [6:0]            window_next [NUM_DIGITS];

    logic [IW-1:0]         idx_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [6:0]            seg_reg;

    logic                  refresh_tick;
    logic                  scroll_tick;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
        .clock  (clock),
        .reset  (reset),
        .en     (1'b1),
        .strobe (refresh_tick)
    );

    // Gating the scroll divider with run is what makes pause lossless: the phase freezes.
    tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
        .clock  (clock),
        .reset  (reset),
        .en     (busy & run),
        .strobe (scroll_tick)
    );

    // Combinational read: a same-cycle write to ptr is seen only on the following step.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_glyph    = mem[ptr_reg];
    assign len_clamped = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    assign last_ptr    = len_reg - LW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            len_reg   <= '0;
            dcnt_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
            dcnt_reg  <= dcnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        len_next    = len_reg;
        dcnt_next   = dcnt_reg;
        done_next   = 1'b0;
        shift_en    = 1'b0;
        shift_glyph = SEG_BLANK;
        case (state_reg)
            IDLE: begin
                if (run && (msg_len != '0)) begin
                    state_next = SCROLL;
                    ptr_next   = '0;
                    len_next   = len_clamped;
                end
            end
            SCROLL: begin
                if (scroll_tick) begin
                    shift_en    = 1'b1;
                    shift_glyph = rd_glyph;
                    ptr_next    = ptr_reg + 1'b1;
                    if (LW'(ptr_reg) == last_ptr) begin
                        state_next = DRAIN;
                        dcnt_next  = DW'(NUM_DIGITS);
                    end
                end
            end
            DRAIN: begin
                if (scroll_tick) begin
                    shift_en  = 1'b1;
                    dcnt_next = dcnt_reg - 1'b1;
                    if (dcnt_reg == DW'(1)) begin
                        done_next = 1'b1;
                        if (loop && run) begin
                            state_next = SCROLL;
                            ptr_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // dir=0 feeds digit 0 and moves glyphs toward higher digits; dir=1 the reverse.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_window
        logic [6:0] from_low;
        logic [6:0] from_high;
        if (gi == 0) begin : g_low_edge
            assign from_low = shift_glyph;
        end else begin : g_low_inner
            assign from_low = window_reg[gi-1];
        end
        if (gi == NUM_DIGITS - 1) begin : g_high_edge
            assign from_high = shift_glyph;
        end else begin : g_high_inner
            assign from_high = window_reg[gi+1];
        end
        assign window_next[gi] = dir ? from_high : from_low;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                window_reg[k] <= SEG_BLANK;
            end
        end else if (shift_en) begin
            window_reg <= window_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_reg <= '0;
            an_reg  <= '1;
            seg_reg <= SEG_BLANK;
        end else begin
            if (refresh_tick) begin
                idx_reg <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
            an_reg  <= ~(AN_ONE << idx_reg);
            seg_reg <= window_reg[idx_reg];
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign busy = (state_reg == SCROLL) || (state_reg == DRAIN);
    assign done = done_reg;

endmodule
